// File: rtl/host_cmd_pkg.sv
// Shared constants and helpers for the host command controller: opcodes, ack
// status codes, ack payload layout and the command-assembler state encoding.
package host_cmd_pkg;

  localparam int ACK_W = 23;

  localparam logic [7:0] OP_SET_CONFIG  = 8'h01;
  localparam logic [7:0] OP_PING        = 8'h02;
  localparam logic [7:0] OP_READ_CONFIG = 8'h03;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BAD_OP  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [1:0] PKT_TYPE_ACK = 2'b11;

  // Ack payload layout: {marker, status[1:0], opcode[3:0], echo[15:0]}
  localparam int ACK_MARKER   = 22;
  localparam int ACK_ST_LSB   = 20;
  localparam int ACK_OP_LSB   = 16;
  localparam int ACK_ECHO_LSB = 0;

  localparam logic [15:0] CMD_TIMEOUT = 16'd48000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GOT1 = 2'd1,
    S_GOT2 = 2'd2,
    S_GOT3 = 2'd3
  } asm_state_t;

  function automatic logic [ACK_W-1:0] make_ack(input logic [1:0]  status,
                                                input logic [3:0]  opcode,
                                                input logic [15:0] echo);
    logic [ACK_W-1:0] p;
    p                        = '0;
    p[ACK_MARKER]            = 1'b1;
    p[ACK_ST_LSB +: 2]       = status;
    p[ACK_OP_LSB +: 4]       = opcode;
    p[ACK_ECHO_LSB +: 16]    = echo;
    return p;
  endfunction

endpackage

// File: rtl/host_cmd_ctrl_ack_fifo.sv
// Two-entry show-ahead FIFO holding pending ack payloads; a write into a full
// FIFO is accepted only when the same edge also pops.
module ack_fifo
  import host_cmd_pkg::*;
(
  input  logic             mclk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [ACK_W-1:0] i_wdata,
  input  logic             i_rd,
  output logic [ACK_W-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  logic [ACK_W-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_wr) r_wptr <= ~r_wptr;
      if (w_do_rd) r_rptr <= ~r_rptr;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full with a simultaneous pop, wptr == rptr: the new entry lands in the slot being freed.
  always_ff @(posedge mclk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/host_cmd_ctrl.sv
// Host command controller: assembles 4-byte host commands, owns the config
// registers and muxes trace packets (priority) with acks. HOST_CMD_TIMEOUT_EN adds the idle timeout.
module host_cmd_ctrl
  import host_cmd_pkg::*;
(
  input  logic        mclk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_strobe,
  input  logic        i_trace_strobe,
  input  logic [1:0]  i_trace_type,
  input  logic [22:0] i_trace_payload,
  output logic        o_packet_strobe,
  output logic [1:0]  o_packet_type,
  output logic [22:0] o_packet_payload,
  output logic        o_trace_enable,
  output logic        o_trace_reads,
  output logic        o_turbo
);

  asm_state_t       r_state;
  logic [7:0]       r_opcode;
  logic [7:0]       r_b2;
  logic             r_trace_enable;
  logic             r_trace_reads;
  logic             r_turbo;
  logic             r_ack_ovf;

  logic             w_cmd_exec;
  logic             w_timeout;
  logic             w_ack_wr;
  logic             w_ack_drop;
  logic             w_is_rdcfg;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [ACK_W-1:0] w_fifo_rdata;
  logic [ACK_W-1:0] w_ack_data;
  logic [1:0]       w_ack_status;
  logic [3:0]       w_ack_op;
  logic [15:0]      w_ack_echo;

  assign w_cmd_exec = i_rx_strobe && (r_state == S_GOT3);
  assign w_is_rdcfg = w_cmd_exec && (r_opcode == OP_READ_CONFIG);
  assign w_ack_wr   = w_cmd_exec || w_timeout;
  assign w_pop      = !i_trace_strobe && !w_fifo_empty;
  assign w_ack_drop = w_ack_wr && w_fifo_full && !w_pop;

`ifdef HOST_CMD_TIMEOUT_EN
  logic [15:0] r_idle_cnt;

  // A byte arriving on the expiry edge takes precedence over the timeout.
  assign w_timeout = !i_rx_strobe && (r_state != S_IDLE) &&
                     (r_idle_cnt == CMD_TIMEOUT - 16'd1);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= 16'd0;
    end else if (i_rx_strobe || (r_state == S_IDLE) || w_timeout) begin
      r_idle_cnt <= 16'd0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_ack_status = ST_OK;
    w_ack_op     = r_opcode[3:0];
    w_ack_echo   = {r_b2, i_rx_data};
    if (w_timeout) begin
      w_ack_status = ST_TIMEOUT;
      w_ack_op     = 4'd0;
      w_ack_echo   = 16'd0;
    end else begin
      case (r_opcode)
        OP_SET_CONFIG, OP_PING: w_ack_status = ST_OK;
        OP_READ_CONFIG: w_ack_echo = {12'd0, r_ack_ovf, r_turbo,
                                      r_trace_reads, r_trace_enable};
        default:        w_ack_status = ST_BAD_OP;
      endcase
    end
  end

  assign w_ack_data = make_ack(w_ack_status, w_ack_op, w_ack_echo);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_trace_enable <= 1'b1;
      r_trace_reads  <= 1'b1;
      r_turbo        <= 1'b0;
      r_ack_ovf      <= 1'b0;
    end else begin
      if (i_rx_strobe) begin
        case (r_state)
          S_IDLE: r_state <= S_GOT1;
          S_GOT1: r_state <= S_GOT2;
          S_GOT2: r_state <= S_GOT3;
          default: begin
            r_state <= S_IDLE;
            if (r_opcode == OP_SET_CONFIG) begin
              r_trace_enable <= i_rx_data[0];
              r_trace_reads  <= i_rx_data[1];
              r_turbo        <= i_rx_data[2];
            end
          end
        endcase
      end else if (w_timeout) begin
        r_state <= S_IDLE;
      end
      if (w_ack_drop)      r_ack_ovf <= 1'b1;
      else if (w_is_rdcfg) r_ack_ovf <= 1'b0;
    end
  end

  // Byte capture; only opcode and D[15:8] need storing, D[7:0] is live on the final strobe.
  always_ff @(posedge mclk) begin
    if (i_rx_strobe) begin
      if (r_state == S_IDLE) r_opcode <= i_rx_data;
      if (r_state == S_GOT2) r_b2     <= i_rx_data;
    end
  end

  ack_fifo u_ack_fifo (
    .mclk    (mclk),
    .reset   (reset),
    .i_wr    (w_ack_wr),
    .i_wdata (w_ack_data),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      o_packet_strobe  <= 1'b0;
      o_packet_type    <= 2'b00;
      o_packet_payload <= 23'd0;
    end else if (i_trace_strobe) begin
      o_packet_strobe  <= 1'b1;
      o_packet_type    <= i_trace_type;
      o_packet_payload <= i_trace_payload;
    end else if (w_pop) begin
      o_packet_strobe  <= 1'b1;
      o_packet_type    <= PKT_TYPE_ACK;
      o_packet_payload <= w_fifo_rdata;
    end else begin
      o_packet_strobe  <= 1'b0;
    end
  end

  assign o_trace_enable = r_trace_enable;
  assign o_trace_reads  = r_trace_reads;
  assign o_turbo        = r_turbo;

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Directed bench for host_cmd_ctrl: command decode, config registers, ack
// format, trace priority with ack overflow, idle timeout and mid-command reset.
module tb_host_cmd_ctrl;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_strobe = 1'b0;
  logic        trace_strobe = 1'b0;
  logic [1:0]  trace_type = 2'd0;
  logic [22:0] trace_payload = 23'd0;
  logic        packet_strobe;
  logic [1:0]  packet_type;
  logic [22:0] packet_payload;
  logic        trace_enable;
  logic        trace_reads;
  logic        turbo;

  int total = 0;
  int bad = 0;

  host_cmd_ctrl dut (
    .mclk             (mclk),
    .reset            (reset),
    .i_rx_data        (rx_data),
    .i_rx_strobe      (rx_strobe),
    .i_trace_strobe   (trace_strobe),
    .i_trace_type     (trace_type),
    .i_trace_payload  (trace_payload),
    .o_packet_strobe  (packet_strobe),
    .o_packet_type    (packet_type),
    .o_packet_payload (packet_payload),
    .o_trace_enable   (trace_enable),
    .o_trace_reads    (trace_reads),
    .o_turbo          (turbo)
  );

  always #5 mclk = ~mclk;

  // Drives four bytes on consecutive edges; returns at the negedge after the final byte's edge.
  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      rx_strobe = 1'b1;
      rx_data   = b[i];
    end
    @(negedge mclk);
    rx_strobe = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge mclk);
    @(negedge mclk);
    reset = 1'b0;
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b0 || packet_type !== 2'b00 || packet_payload !== 23'd0) begin
      bad++;
      $display("FAIL reset_pkt: got strobe=%b type=%b payload=%h, want 0/00/000000",
               packet_strobe, packet_type, packet_payload);
    end
    total++;
    if ({trace_enable, trace_reads, turbo} !== 3'b110) begin
      bad++;
      $display("FAIL reset_cfg: got en/rd/turbo=%b, want 110", {trace_enable, trace_reads, turbo});
    end
  endtask

  task automatic test_read_config_reset();
    send_cmd(8'h03, 8'h00, 8'h00, 8'h00);
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_type !== 2'b11 || packet_payload !== 23'h430003) begin
      bad++;
      $display("FAIL rdcfg_reset: got strobe=%b type=%b payload=%h, want 1/11/430003",
               packet_strobe, packet_type, packet_payload);
    end
  endtask

  task automatic test_set_config();
    send_cmd(8'h01, 8'h00, 8'h00, 8'h05);
    total++;
    if ({trace_enable, trace_reads, turbo} !== 3'b101) begin
      bad++;
      $display("FAIL setcfg_cfg: got en/rd/turbo=%b, want 101", {trace_enable, trace_reads, turbo});
    end
    total++;
    if (packet_strobe !== 1'b0) begin
      bad++;
      $display("FAIL setcfg_early: ack visible at write edge, got strobe=%b want 0", packet_strobe);
    end
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_type !== 2'b11 || packet_payload !== 23'h410005) begin
      bad++;
      $display("FAIL setcfg_ack: got strobe=%b type=%b payload=%h, want 1/11/410005",
               packet_strobe, packet_type, packet_payload);
    end
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b0) begin
      bad++;
      $display("FAIL setcfg_single: got strobe=%b want 0", packet_strobe);
    end
  endtask

  task automatic test_bad_op();
    send_cmd(8'h7F, 8'h00, 8'h12, 8'h34);
    total++;
    if ({trace_enable, trace_reads, turbo} !== 3'b101) begin
      bad++;
      $display("FAIL badop_cfg: got en/rd/turbo=%b, want 101", {trace_enable, trace_reads, turbo});
    end
    @(posedge mclk); #1;
    // status 01 at bits 21:20 plus marker bit 22 and opcode nibble F
    total++;
    if (packet_strobe !== 1'b1 || packet_type !== 2'b11 || packet_payload !== 23'h5F1234) begin
      bad++;
      $display("FAIL badop_ack: got strobe=%b type=%b payload=%h, want 1/11/5F1234",
               packet_strobe, packet_type, packet_payload);
    end
  endtask

  task automatic test_timeout();
    int first_seen;
    logic [22:0] seen_payload;
    first_seen   = 0;
    seen_payload = 23'd0;
    @(negedge mclk);
    rx_strobe = 1'b1;
    rx_data   = 8'h02;
    @(negedge mclk);
    rx_strobe = 1'b0;
    for (int k = 1; k <= 48001; k++) begin
      @(posedge mclk); #1;
      if (packet_strobe === 1'b1 && first_seen == 0) begin
        first_seen   = k;
        seen_payload = packet_payload;
      end
    end
`ifdef HOST_CMD_TIMEOUT_EN
    total++;
    if (first_seen != 48001 || seen_payload !== 23'h600000) begin
      bad++;
      $display("FAIL timeout_ack: got cycle=%0d payload=%h, want cycle=48001 payload=600000",
               first_seen, seen_payload);
    end
    send_cmd(8'h02, 8'h00, 8'hAB, 8'hCD);
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_payload !== 23'h42ABCD) begin
      bad++;
      $display("FAIL timeout_idle: got strobe=%b payload=%h, want 1/42ABCD",
               packet_strobe, packet_payload);
    end
`else
    total++;
    if (first_seen != 0) begin
      bad++;
      $display("FAIL notimeout_quiet: got packet at cycle %0d payload=%h, want none",
               first_seen, seen_payload);
    end
    // The pending PING opcode is still held; three more bytes complete it.
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      rx_strobe = 1'b1;
      rx_data   = (i == 0) ? 8'h00 : ((i == 1) ? 8'h11 : 8'h22);
    end
    @(negedge mclk);
    rx_strobe = 1'b0;
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_payload !== 23'h421122) begin
      bad++;
      $display("FAIL notimeout_resume: got strobe=%b payload=%h, want 1/421122",
               packet_strobe, packet_payload);
    end
`endif
  endtask

  task automatic test_trace_priority();
    logic [7:0]  bytes [12];
    logic [1:0]  exp_t;
    logic [22:0] exp_p;
    bytes = '{8'h02, 8'h00, 8'h00, 8'h01,
              8'h02, 8'h00, 8'h00, 8'h02,
              8'h02, 8'h00, 8'h00, 8'h03};
    for (int c = 0; c < 14; c++) begin
      @(negedge mclk);
      trace_strobe  = 1'b1;
      trace_type    = 2'(c % 4);
      trace_payload = {1'b0, 22'(c * 22'h013579 + 22'h00000A)};
      if (c < 12) begin
        rx_strobe = 1'b1;
        rx_data   = bytes[c];
      end else begin
        rx_strobe = 1'b0;
      end
      exp_t = trace_type;
      exp_p = trace_payload;
      @(posedge mclk); #1;
      total++;
      if (packet_strobe !== 1'b1 || packet_type !== exp_t || packet_payload !== exp_p) begin
        bad++;
        $display("FAIL trace_pass[%0d]: got strobe=%b type=%b payload=%h, want 1/%b/%h",
                 c, packet_strobe, packet_type, packet_payload, exp_t, exp_p);
      end
    end
    @(negedge mclk);
    trace_strobe = 1'b0;
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_type !== 2'b11 || packet_payload !== 23'h420001) begin
      bad++;
      $display("FAIL drain_ack1: got strobe=%b type=%b payload=%h, want 1/11/420001",
               packet_strobe, packet_type, packet_payload);
    end
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_type !== 2'b11 || packet_payload !== 23'h420002) begin
      bad++;
      $display("FAIL drain_ack2: got strobe=%b type=%b payload=%h, want 1/11/420002",
               packet_strobe, packet_type, packet_payload);
    end
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b0) begin
      bad++;
      $display("FAIL drain_dropped: third ack emitted, payload=%h, want strobe=0", packet_payload);
    end
    // ovf=1 turbo=1 reads=0 en=1 -> echo 0xD
    send_cmd(8'h03, 8'h00, 8'h00, 8'h00);
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_payload !== 23'h43000D) begin
      bad++;
      $display("FAIL ovf_report: got strobe=%b payload=%h, want 1/43000D",
               packet_strobe, packet_payload);
    end
    send_cmd(8'h03, 8'h00, 8'h00, 8'h00);
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_payload !== 23'h430005) begin
      bad++;
      $display("FAIL ovf_cleared: got strobe=%b payload=%h, want 1/430005",
               packet_strobe, packet_payload);
    end
  endtask

  task automatic test_reset_mid_cmd();
    int extra;
    extra = 0;
    @(negedge mclk);
    trace_strobe  = 1'b1;
    trace_type    = 2'b01;
    trace_payload = 23'h0F0F0F;
    send_cmd(8'h02, 8'h00, 8'h00, 8'h09);
    @(negedge mclk);
    rx_strobe = 1'b1;
    rx_data   = 8'h01;
    @(negedge mclk);
    rx_data   = 8'hFF;
    @(negedge mclk);
    rx_strobe    = 1'b0;
    trace_strobe = 1'b0;
    reset        = 1'b1;
    @(negedge mclk);
    reset = 1'b0;
    total++;
    if ({trace_enable, trace_reads, turbo} !== 3'b110 || packet_strobe !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: got cfg=%b strobe=%b, want 110/0",
               {trace_enable, trace_reads, turbo}, packet_strobe);
    end
    send_cmd(8'h02, 8'h00, 8'hAB, 8'hCD);
    total++;
    if (packet_strobe !== 1'b0) begin
      bad++;
      $display("FAIL midreset_stale: got strobe=%b payload=%h before new ack, want 0",
               packet_strobe, packet_payload);
    end
    @(posedge mclk); #1;
    total++;
    if (packet_strobe !== 1'b1 || packet_type !== 2'b11 || packet_payload !== 23'h42ABCD) begin
      bad++;
      $display("FAIL midreset_ack: got strobe=%b type=%b payload=%h, want 1/11/42ABCD",
               packet_strobe, packet_type, packet_payload);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge mclk); #1;
      if (packet_strobe === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL midreset_extra: got %0d extra packets, want 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_read_config_reset();
    test_set_config();
    test_bad_op();
    test_timeout();
    test_trace_priority();
    test_reset_mid_cmd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
